// File: rtl/dp_pkg.sv
// Shared definitions for the datapath_seq codebase slice.
//
// Holds the opcode encoding, the bit positions of the five status flags
// inside the {PF,OF,SF,ZF,CF} flag vector, the controller state type and
// a small helper that says which opcodes update the flags register.
//
// Configuration macro used by the files importing this package:
//   DATAPATH_SEQ_CARRY_CHAIN_EN - enables ADC/SBB (otherwise illegal).
package dp_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL1 = 4'd6,
    OP_SHR1 = 4'd7,
    OP_MOV  = 4'd8,
    OP_ADC  = 4'd9,
    OP_SBB  = 4'd10
  } op_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;
  localparam int FLAG_PF = 4;
  localparam int NFLAGS  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  // NOT and MOV are pure data moves: they write a register but must leave
  // the flags register alone.
  function automatic logic op_writes_flags(input logic [3:0] op);
    return !((op == OP_NOT) || (op == OP_MOV));
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for datapath_seq.
//
// Ports:
//   a, b   - operands (WIDTH bits)
//   op     - 4-bit opcode (dp_pkg::op_e encoding)
//   cin    - stored carry flag, consumed by ADC/SBB
//   result - WIDTH-bit result, 0 for illegal opcodes
//   flags  - {PF,OF,SF,ZF,CF} computed from this operation
//   legal  - 1 when op is implemented in this build
//
// Macro DATAPATH_SEQ_CARRY_CHAIN_EN: when defined ADC/SBB are implemented,
// otherwise opcodes 9 and 10 fall into the illegal group.
module dp_alu
  import dp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [3:0]        op,
  input  logic              cin,
  output logic [WIDTH-1:0]  result,
  output logic [NFLAGS-1:0] flags,
  output logic              legal
);

  logic [WIDTH:0] ext;
  logic           cf;
  logic           of;

`ifndef DATAPATH_SEQ_CARRY_CHAIN_EN
  logic unused_cin;
  assign unused_cin = cin;
`endif

  // Arithmetic is done one bit wider so the top bit is the carry-out for
  // additions and the borrow for subtractions.
  always_comb begin
    ext    = '0;
    result = '0;
    cf     = 1'b0;
    of     = 1'b0;
    legal  = 1'b1;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        cf     = ext[WIDTH];
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        cf     = ext[WIDTH];
        of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL1: begin
        result = {a[WIDTH-2:0], 1'b0};
        cf     = a[WIDTH-1];
        of     = a[WIDTH-1] ^ a[WIDTH-2];
      end
      OP_SHR1: begin
        result = {1'b0, a[WIDTH-1:1]};
        cf     = a[0];
        of     = a[WIDTH-1];
      end
      OP_MOV:  result = b;
`ifdef DATAPATH_SEQ_CARRY_CHAIN_EN
      OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = ext[WIDTH-1:0];
        cf     = ext[WIDTH];
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SBB: begin
        ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        result = ext[WIDTH-1:0];
        cf     = ext[WIDTH];
        of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
`endif
      default: begin
        legal  = 1'b0;
        result = '0;
      end
    endcase
  end

  // PF is even parity of the low byte: set when the count of ones is even.
  always_comb begin
    flags          = '0;
    flags[FLAG_CF] = cf;
    flags[FLAG_ZF] = (result == '0);
    flags[FLAG_SF] = result[WIDTH-1];
    flags[FLAG_OF] = of;
    flags[FLAG_PF] = ~^result[7:0];
  end

endmodule

// File: rtl/datapath_seq.sv
// Sequential single-issue datapath: register file + flags + ALU behind a
// valid/ready request channel and a valid/ready response channel.
//
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous, active-low reset
//   req_valid/req_ready                 - request handshake
//   req_op, req_dst, req_src_a, req_src_b, req_imm_sel, req_imm - request
//   resp_valid/resp_ready               - response handshake
//   resp_result, resp_flags {PF,OF,SF,ZF,CF}, resp_err          - response
//
// Flow: IDLE accepts and latches a request, READ registers the operands,
// EXEC writes the register file / flags and registers the response, RESP
// holds it until the consumer takes it.
//
// Macro DATAPATH_SEQ_CARRY_CHAIN_EN: enables ADC/SBB inside dp_alu.
module datapath_seq
  import dp_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [AW-1:0]     req_dst,
  input  logic [AW-1:0]     req_src_a,
  input  logic [AW-1:0]     req_src_b,
  input  logic              req_imm_sel,
  input  logic [WIDTH-1:0]  req_imm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic [NFLAGS-1:0] resp_flags,
  output logic              resp_err
);

  state_e            state_q, state_d;
  logic              ready_en_q, ready_en_d;
  logic [3:0]        op_q, op_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [AW-1:0]     src_a_q, src_a_d;
  logic [AW-1:0]     src_b_q, src_b_d;
  logic              imm_sel_q, imm_sel_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]  resp_result_q, resp_result_d;
  logic [NFLAGS-1:0] resp_flags_q, resp_flags_d;
  logic              resp_err_q, resp_err_d;

  logic [WIDTH-1:0]  alu_result;
  logic [NFLAGS-1:0] alu_flags;
  logic              alu_legal;

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .cin    (flags_q[FLAG_CF]),
    .result (alu_result),
    .flags  (alu_flags),
    .legal  (alu_legal)
  );

  // ready_en_q holds req_ready low while reset is asserted and lets it rise
  // on the first clock after reset is released.
  assign req_ready   = (state_q == IDLE) && ready_en_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;

  always_comb begin
    state_d       = state_q;
    ready_en_d    = 1'b1;
    op_d          = op_q;
    dst_d         = dst_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    imm_sel_d     = imm_sel_q;
    imm_d         = imm_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    regs_d        = regs_q;
    flags_d       = flags_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d      = req_op;
          dst_d     = req_dst;
          src_a_d   = req_src_a;
          src_b_d   = req_src_b;
          imm_sel_d = req_imm_sel;
          imm_d     = req_imm;
          state_d   = READ;
        end
      end
      READ: begin
        // Operands are captured before EXEC writes back, so a destination
        // that aliases a source still sees the old value.
        opa_d   = regs_q[src_a_q];
        opb_d   = imm_sel_q ? imm_q : regs_q[src_b_q];
        state_d = EXEC;
      end
      EXEC: begin
        if (alu_legal) begin
          regs_d[dst_q] = alu_result;
          if (op_writes_flags(op_q)) begin
            flags_d = alu_flags;
          end
        end
        resp_valid_d  = 1'b1;
        resp_result_d = alu_legal ? alu_result : '0;
        resp_flags_d  = flags_d;
        resp_err_d    = !alu_legal;
        state_d       = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ready_en_q    <= 1'b0;
      op_q          <= '0;
      dst_q         <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      imm_sel_q     <= 1'b0;
      imm_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      regs_q        <= '{default: '0};
      flags_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_en_q    <= ready_en_d;
      op_q          <= op_d;
      dst_q         <= dst_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      imm_sel_q     <= imm_sel_d;
      imm_q         <= imm_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      regs_q        <= regs_d;
      flags_q       <= flags_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule
